// File: rtl/rot_pkg.sv
// Shared constants and types for the rotate arbiter and its combinational rotator.
package rot_pkg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    localparam logic LR_RIGHT = 1'b0;
    localparam logic LR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rotate8.sv
// Purely combinational 8-bit rotator built from 1/2/4-position stages.
module rotate8
    import rot_pkg::*;
(
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             lr_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;
    logic [WIDTH-1:0] stage4;

    always_comb begin
        stage1 = data_i;
        if (amt_i[0]) begin
            stage1 = (lr_i == LR_LEFT) ? {data_i[6:0], data_i[7]} : {data_i[0], data_i[7:1]};
        end
        stage2 = stage1;
        if (amt_i[1]) begin
            stage2 = (lr_i == LR_LEFT) ? {stage1[5:0], stage1[7:6]} : {stage1[1:0], stage1[7:2]};
        end
        // A half-width rotate is identical in both directions.
        stage4 = amt_i[2] ? {stage2[3:0], stage2[7:4]} : stage2;
    end

    assign data_o = stage4;

endmodule

// File: rtl/rot_arbiter.sv
// Two-requester arbiter in front of a single shared rotator; one operation in flight,
// result returned with the owning requester id over a valid/ready handshake.
module rot_arbiter #(
    parameter int WIDTH      = 8,
    parameter int AMT_W      = 3,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_lr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_lr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);

    rot_pkg::state_e  state_q, state_d;
    rot_pkg::req_id_t grant;
    rot_pkg::req_id_t last_grant_q, last_grant_d;
    rot_pkg::req_id_t id_q, id_d;
    rot_pkg::req_id_t rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             lr_q, lr_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rot_result;
    logic             accept;

    rotate8 u_rotate8 (
        .data_i (data_q),
        .amt_i  (amt_q),
        .lr_i   (lr_q),
        .data_o (rot_result)
    );

    // On a tie the requester that did not win last time goes next, unless req0 is favoured.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        req0_ready = (state_q == rot_pkg::ST_IDLE) && req0_valid && (grant == 1'b0);
        req1_ready = (state_q == rot_pkg::ST_IDLE) && req1_valid && (grant == 1'b1);
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        // NOTE: every next-state signal is defaulted to its register first so no path through
        // the case statement leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        data_d       = data_q;
        amt_d        = amt_q;
        lr_d         = lr_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;

        case (state_q)
            rot_pkg::ST_IDLE: begin
                if (accept) begin
                    data_d       = grant ? req1_data : req0_data;
                    amt_d        = grant ? req1_amt  : req0_amt;
                    lr_d         = grant ? req1_lr   : req0_lr;
                    id_d         = grant;
                    last_grant_d = grant;
                    state_d      = rot_pkg::ST_EXEC;
                end
            end
            rot_pkg::ST_EXEC: begin
                rsp_data_d  = rot_result;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = rot_pkg::ST_RESP;
            end
            rot_pkg::ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = rot_pkg::ST_IDLE;
                end
            end
            default: begin
                state_d = rot_pkg::ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples the values
    // from before this edge; reset is synchronous and overrides any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= rot_pkg::ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            data_q       <= '0;
            amt_q        <= '0;
            lr_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            data_q       <= data_d;
            amt_q        <= amt_d;
            lr_q         <= lr_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_rot_arbiter.sv
// Checks a round-robin and a fixed-priority rot_arbiter against a cycle-level behavioural model.
module tb_rot_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_data [2];
    logic [2:0] req_amt  [2];
    logic [1:0] req_lr;
    logic       rsp_ready;

    logic [1:0] rdy_rr, rdy_fp;
    logic       rv_rr, rv_fp;
    logic [7:0] rd_rr, rd_fp;
    logic       rid_rr, rid_fp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rot_arbiter #(.WIDTH(8), .AMT_W(3), .FIXED_PRIO(1'b0)) u_dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ready(rdy_rr[0]), .req0_data(req_data[0]),
        .req0_amt(req_amt[0]), .req0_lr(req_lr[0]),
        .req1_valid(req_valid[1]), .req1_ready(rdy_rr[1]), .req1_data(req_data[1]),
        .req1_amt(req_amt[1]), .req1_lr(req_lr[1]),
        .rsp_valid(rv_rr), .rsp_ready(rsp_ready), .rsp_data(rd_rr), .rsp_id(rid_rr)
    );

    rot_arbiter #(.WIDTH(8), .AMT_W(3), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ready(rdy_fp[0]), .req0_data(req_data[0]),
        .req0_amt(req_amt[0]), .req0_lr(req_lr[0]),
        .req1_valid(req_valid[1]), .req1_ready(rdy_fp[1]), .req1_data(req_data[1]),
        .req1_amt(req_amt[1]), .req1_lr(req_lr[1]),
        .rsp_valid(rv_fp), .rsp_ready(rsp_ready), .rsp_data(rd_fp), .rsp_id(rid_fp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-index definition of rotation: right takes in[(i+amt) mod 8], left takes in[(i-amt) mod 8].
    function automatic logic [7:0] model_rot(input logic [7:0] x, input int amt, input bit left);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = left ? x[(i - amt + 8) % 8] : x[(i + amt) % 8];
        end
        return r;
    endfunction

    // Model: at most one operation outstanding; an accept makes the result visible two cycles later.
    bit         cmp_on = 1'b0;
    bit         m_busy  [2];
    int         m_delay [2];
    bit         m_last  [2];
    logic [7:0] m_rdata [2];
    bit         m_rid   [2];
    int         acc_cnt [2][2];
    int         rsp_cnt [2][2];
    bit [1:0]   acc_flag;
    bit [1:0]   e_rdy;
    bit         e_win;
    bit         e_v;
    logic [1:0] a_rdy;
    logic       a_v;
    logic [7:0] a_d;
    logic       a_id;

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int m = 0; m < 2; m++) begin
                a_rdy = (m == 0) ? rdy_rr : rdy_fp;
                a_v   = (m == 0) ? rv_rr  : rv_fp;
                a_d   = (m == 0) ? rd_rr  : rd_fp;
                a_id  = (m == 0) ? rid_rr : rid_fp;

                e_v   = m_busy[m] && (m_delay[m] == 0);
                e_rdy = 2'b00;
                e_win = 1'b0;
                if (!m_busy[m] && req_valid != 2'b00) begin
                    if (req_valid == 2'b11) e_win = (m == 1) ? 1'b0 : !m_last[m];
                    else                    e_win = req_valid[1];
                    e_rdy[e_win] = 1'b1;
                end

                check((m == 0) ? "rr_ready" : "fp_ready", 32'(a_rdy), 32'(e_rdy));
                check((m == 0) ? "rr_rsp_valid" : "fp_rsp_valid", 32'(a_v), 32'(e_v));
                if (e_v) begin
                    check((m == 0) ? "rr_rsp_data" : "fp_rsp_data", 32'(a_d), 32'(m_rdata[m]));
                    check((m == 0) ? "rr_rsp_id" : "fp_rsp_id", 32'(a_id), 32'(m_rid[m]));
                end

                if (rst) begin
                    m_busy[m] = 1'b0;
                    m_last[m] = 1'b1;
                end else if (m_busy[m]) begin
                    if (m_delay[m] > 0) begin
                        m_delay[m]--;
                    end else if (rsp_ready) begin
                        m_busy[m] = 1'b0;
                        rsp_cnt[m][m_rid[m]]++;
                    end
                end else if (e_rdy != 2'b00) begin
                    m_busy[m]  = 1'b1;
                    m_delay[m] = 1;
                    m_last[m]  = e_win;
                    m_rid[m]   = e_win;
                    m_rdata[m] = model_rot(req_data[e_win], int'(req_amt[e_win]), req_lr[e_win]);
                    acc_cnt[m][e_win]++;
                end
                if (m == 0) acc_flag = rst ? 2'b00 : e_rdy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int r, input string name);
        int n = 0;
        @(negedge clk);
        while (!rdy_rr[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_grant"}, 32'(rdy_rr[r]), 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        @(negedge clk);
        while (!rv_rr && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_seen"}, 32'(rv_rr), 32'd1);
    endtask

    task automatic single_op(input int r, input logic [7:0] data, input logic [2:0] amt,
                             input bit lr, input logic [7:0] exp, input string name);
        req_valid    = 2'b00;
        req_valid[r] = 1'b1;
        req_data[r]  = data;
        req_amt[r]   = amt;
        req_lr[r]    = lr;
        rsp_ready    = 1'b1;
        wait_ready(r, name);
        tick();
        req_valid[r] = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, 32'(rv_rr), 32'd0);
        @(negedge clk);
        check({name, "_lat2"}, 32'(rv_rr), 32'd1);
        check({name, "_data"}, 32'(rd_rr), 32'(exp));
        check({name, "_id"}, 32'(rid_rr), 32'(r));
        tick();
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        req_valid = 2'b00;
        req_lr    = 2'b00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_data[i] = 8'h00;
            req_amt[i]  = 3'd0;
            m_busy[i]   = 1'b0;
            m_delay[i]  = 0;
            m_last[i]   = 1'b1;
            m_rdata[i]  = 8'h00;
            m_rid[i]    = 1'b0;
        end
        repeat (2) tick();
        cmp_on = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", 32'(rv_rr), 32'd0);
        check("reset_rsp_data", 32'(rd_rr), 32'd0);
        check("reset_rsp_id", 32'(rid_rr), 32'd0);
        check("reset_ready", 32'(rdy_rr), 32'd0);
        tick();

        single_op(0, 8'h81, 3'd1, 1'b0, 8'hC0, "r0_right1");
        single_op(0, 8'h81, 3'd1, 1'b1, 8'h03, "r0_left1");
        single_op(1, 8'hA5, 3'd4, 1'b0, 8'h5A, "r1_right4");
        single_op(1, 8'hA5, 3'd4, 1'b1, 8'h5A, "r1_left4");
        single_op(1, 8'h3C, 3'd0, 1'b0, 8'h3C, "r1_amt0_r");
        single_op(1, 8'h3C, 3'd0, 1'b1, 8'h3C, "r1_amt0_l");

        // Both requesters held valid straight out of reset.
        rst         = 1'b1;
        req_valid   = 2'b11;
        req_data[0] = 8'h01; req_amt[0] = 3'd7; req_lr[0] = 1'b1;
        req_data[1] = 8'h80; req_amt[1] = 3'd1; req_lr[1] = 1'b0;
        rsp_ready   = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_rsp("tie");
            check("tie_rr_id", 32'(rid_rr), 32'(k % 2));
            check("tie_rr_data", 32'(rd_rr), (k % 2 == 1) ? 32'h40 : 32'h80);
            check("tie_fp_valid", 32'(rv_fp), 32'd1);
            check("tie_fp_id", 32'(rid_fp), 32'd0);
            check("tie_fp_data", 32'(rd_fp), 32'h80);
        end
        tick();
        req_valid = 2'b00;
        tick();

        // Consumer stalls for five cycles while req1 waits.
        req_valid   = 2'b01;
        req_data[0] = 8'h81; req_amt[0] = 3'd1; req_lr[0] = 1'b0;
        rsp_ready   = 1'b0;
        wait_ready(0, "stall");
        tick();
        req_valid   = 2'b10;
        req_data[1] = 8'h3C; req_amt[1] = 3'd0; req_lr[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(rv_rr), 32'd1);
            check("stall_data", 32'(rd_rr), 32'hC0);
            check("stall_id", 32'(rid_rr), 32'd0);
            check("stall_ready", 32'(rdy_rr), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 32'(rv_rr), 32'd1);
        @(negedge clk);
        check("stall_idle_valid", 32'(rv_rr), 32'd0);
        check("stall_next_grant", 32'(rdy_rr), 32'b10);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("stall_next_data", 32'(rd_rr), 32'h3C);
        check("stall_next_id", 32'(rid_rr), 32'd1);
        tick();

        // Reset while the granted operation is executing.
        req_valid   = 2'b11;
        req_data[0] = 8'h81; req_amt[0] = 3'd1; req_lr[0] = 1'b0;
        req_data[1] = 8'hA5; req_amt[1] = 3'd4; req_lr[1] = 1'b1;
        @(negedge clk);
        check("exec_abort_grant", 32'(rdy_rr), 32'b01);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("exec_abort_valid", 32'(rv_rr), 32'd0);
        check("exec_abort_data", 32'(rd_rr), 32'd0);
        check("exec_abort_id", 32'(rid_rr), 32'd0);
        check("exec_abort_tie", 32'(rdy_rr), 32'b01);

        // Reset while a result is waiting for the consumer.
        tick();
        rsp_ready = 1'b0;
        tick();
        @(negedge clk);
        check("resp_abort_pre_valid", 32'(rv_rr), 32'd1);
        check("resp_abort_pre_data", 32'(rd_rr), 32'hC0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("resp_abort_valid", 32'(rv_rr), 32'd0);
        check("resp_abort_data", 32'(rd_rr), 32'd0);
        check("resp_abort_tie", 32'(rdy_rr), 32'b01);
        tick();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) tick();

        // Random traffic with random consumer back-pressure.
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 2; r++) begin
                acc_cnt[m][r] = 0;
                rsp_cnt[m][r] = 0;
            end
        end
        cyc = 0;
        while ((acc_cnt[0][0] + acc_cnt[0][1]) < 2000 && cyc < 40000) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] || acc_flag[r] || $urandom_range(0, 15) == 0) begin
                    req_valid[r] = ($urandom_range(0, 2) != 0);
                    req_data[r]  = 8'($urandom);
                    req_amt[r]   = 3'($urandom);
                    req_lr[r]    = 1'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (6) tick();
        check("random_op_count", 32'((acc_cnt[0][0] + acc_cnt[0][1]) >= 2000), 32'd1);
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 2; r++) begin
                check((m == 0) ? "rr_rsp_count" : "fp_rsp_count",
                      32'(rsp_cnt[m][r]), 32'(acc_cnt[m][r]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rot_arbiter.md
Name: rot_arbiter

Overview:
- Shares one 8-bit combinational rotate unit between two independent requesters.
- Arbitrates round-robin (optionally fixed priority) and registers the winning request's operands.
- Drives the shared rotator from those registered operands and returns the result tagged with the requester id.
- Output uses a valid/ready handshake.
- Sits between the two control paths that need rotates and the single shared rotator.

Parameters:
- WIDTH, 8, data width; only 8 is supported (rotator is 8-bit).
- AMT_W, 3, rotate-amount width, equal to log2(WIDTH).
- FIXED_PRIO, 0, 0 = round-robin; 1 = req0 always wins ties.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0's operation is accepted this cycle.
- req0_data  input  WIDTH  operand.
- req0_amt  input  AMT_W  rotate amount, 0..7.
- req0_lr  input  1  direction: 0 = rotate right, 1 = rotate left.
- req1_valid, req1_ready, req1_data, req1_amt, req1_lr  same as requester 0.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WIDTH  rotated result.
- rsp_id  output  1  requester that owns rsp_data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0.
  - reqN_ready=0, operand registers=0.
  - last_grant=1, so req0 wins the first tie.
  - Reset dominates every other event, including mid-operation; any in-flight operation is discarded with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = single valid requester if only one is valid.
  - If both are valid: with FIXED_PRIO=1, req0 wins; with FIXED_PRIO=0, the requester not equal to last_grant wins.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. This is combinational; requesters must not make valid depend on ready.
  - On handshake: capture data/amt/lr/id, set last_grant=id, go to EXEC.
  - No valid requests: stay in IDLE.
- EXEC (1 cycle):
  - The shared rotator evaluates the registered operands.
  - Result is registered into rsp_data, rsp_id is set, rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id hold stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: rsp_valid=0, go to IDLE.
  - reqN_ready=0 in EXEC and RESP.
- Latency and throughput:
  - Request handshake in cycle N gives rsp_valid high from cycle N+2.
  - Maximum throughput is one operation per 3 cycles; there are no back-to-back accepts.
- Rotate semantics:
  - Right: out[i] = in[(i+amt) mod 8]. Left: out[i] = in[(i-amt) mod 8].
  - Pure rotation: no bits lost or filled.
  - amt=0 passes data through unchanged, for either direction.
- Request contract: requester operands must stay stable while valid && !ready. Dropping valid before the handshake is allowed; the dropped request is simply not granted.
- last_grant updates only on an accepted handshake, never on a mere request.
- A requester that holds valid continuously is guaranteed service at least every second grant under round-robin.

Decomposition:
- Shared package rot_pkg:
  - WIDTH/AMT_W constants.
  - LR_RIGHT=0 and LR_LEFT=1 constants.
  - State encoding for IDLE/EXEC/RESP.
  - Requester-id type (1 bit).
- Sub-module rotate8: purely combinational 3-stage (1/2/4) rotator with inputs data, amt, lr and output data, instantiated once.
- Arbitration, FSM and registers live in rot_arbiter.

Test Plan:
- req0 only: data=0x81, amt=1, lr=0 -> req0_ready pulse, rsp_valid 2 cycles later, rsp_data=0xC0, rsp_id=0. Repeat with lr=1 -> rsp_data=0x03.
- req1 only: data=0xA5, amt=4, then both directions -> 0x5A each time. data=0x3C, amt=0 -> 0x3C.
- Both valid and held after reset (req0 data=0x01 amt=7 lr=1; req1 data=0x80 amt=1 lr=0) -> req0 granted first (rsp 0x80, id 0), then req1 (rsp 0x40, id 1). Grants keep alternating 0,1,0,1 while both stay valid. With FIXED_PRIO=1, req0 wins every time.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, both reqN_ready=0. Raising rsp_ready -> IDLE next cycle, next grant follows.
- rst asserted in EXEC, then in RESP -> next cycle all outputs at reset values, no response emitted. After release, a tie grants req0.
- Random rotates (2000 ops, random valid/rsp_ready) checked against the rotate semantics above -> all results correct, ordered per id, no lost or duplicated responses.
